// File: rtl/uart_core_p_if.sv
// Host-side parallel bus of uart_core_p: receive word with its strobe and
// transmit word with its request/permit handshake.
interface uart_core_p_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS+1:0] PalDataOut;
   logic                 PalDataOutValid;
   logic [DATA_BITS-1:0] PalDataIn;
   logic                 PalDataInEn;
   logic                 PalDataInPermit;

   modport master (
      output PalDataIn, PalDataInEn,
      input  PalDataOut, PalDataOutValid, PalDataInPermit
   );

   modport slave (
      input  PalDataIn, PalDataInEn,
      output PalDataOut, PalDataOutValid, PalDataInPermit
   );
endinterface

// File: rtl/uart_core_p.sv
// Parametrised full-duplex UART core with majority-vote receive sampling,
// parity/framing error flags and an internal loopback path.
module uart_core_p #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16,
   parameter int PRESCALE   = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic LoopBack,
   input  logic SerDataIn,
   output logic SerDataOut,
   uart_core_p_if.slave host
);
   localparam int CPB = OVERSAMPLE * PRESCALE;
   localparam int CW  = $clog2(CPB);
   localparam logic [CW-1:0] LAST  = CW'(CPB - 1);
   localparam logic [CW-1:0] SAMP0 = CW'(CPB / 2 - 2);
   localparam logic [CW-1:0] SAMP1 = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] SAMP2 = CW'(CPB / 2);
   localparam logic [3:0]    LASTDATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LASTSTOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               r_txState, w_txStateNext;
   logic [CW-1:0]        r_txCnt, w_txCntNext;
   logic [3:0]           r_txBit, w_txBitNext;
   logic [DATA_BITS-1:0] r_txShift, w_txShiftNext;
   logic                 r_txParity, w_txParityNext;
   logic                 w_txLine, w_txAccept, w_txBitEnd;

   state_t               r_rxState, w_rxStateNext;
   logic [CW-1:0]        r_rxCnt, w_rxCntNext;
   logic [3:0]           r_rxBit, w_rxBitNext;
   logic [DATA_BITS-1:0] r_rxShift, w_rxShiftNext;
   logic                 r_rxParBit, w_rxParBitNext;
   logic                 r_samp0, w_samp0Next, r_samp1, w_samp1Next;
   logic [DATA_BITS+1:0] r_rxOut, w_rxOutNext;
   logic                 r_rxValid, w_rxValidNext;
   logic                 r_sync1, r_sync2, r_prev;
   logic                 w_rxLine, w_rxMaj, w_rxCenter, w_rxBitEnd;
   logic                 w_parXor, w_parErr;

   assign host.PalDataInPermit = (r_txState == IDLE) && !rst;
   assign w_txAccept           = host.PalDataInEn && host.PalDataInPermit;
   assign w_txBitEnd           = (r_txCnt == LAST);
   assign SerDataOut           = LoopBack ? 1'b1 : w_txLine;

   assign w_rxLine   = LoopBack ? w_txLine : SerDataIn;
   assign w_rxMaj    = (r_samp0 & r_samp1) | (r_samp0 & r_sync2) | (r_samp1 & r_sync2);
   assign w_rxCenter = (r_rxCnt == SAMP2);
   assign w_rxBitEnd = (r_rxCnt == LAST);
   assign w_parXor   = ^{r_rxShift, r_rxParBit};
   assign w_parErr   = (PARITY == 1) ? ~w_parXor : ((PARITY == 2) ? w_parXor : 1'b0);

   assign host.PalDataOut      = r_rxOut;
   assign host.PalDataOutValid = r_rxValid;

   // Transmit sequencing: bit timer, bit index and the serial line level per state.
   always_comb begin
      w_txStateNext  = r_txState;
      w_txCntNext    = r_txCnt + 1'b1;
      w_txBitNext    = r_txBit;
      w_txShiftNext  = r_txShift;
      w_txParityNext = r_txParity;
      w_txLine       = 1'b1;
      case (r_txState)
         IDLE: begin
            w_txCntNext = '0;
            if (w_txAccept) begin
               w_txStateNext  = START;
               w_txShiftNext  = host.PalDataIn;
               w_txParityNext = (PARITY == 1) ? ~^host.PalDataIn : ^host.PalDataIn;
               w_txBitNext    = '0;
            end
         end
         START: begin
            w_txLine = 1'b0;
            if (w_txBitEnd) begin
               w_txStateNext = DATA;
               w_txCntNext   = '0;
               w_txBitNext   = '0;
            end
         end
         DATA: begin
            w_txLine = r_txShift[0];
            if (w_txBitEnd) begin
               w_txCntNext   = '0;
               w_txShiftNext = r_txShift >> 1;
               if (r_txBit == LASTDATA) begin
                  w_txBitNext   = '0;
                  w_txStateNext = (PARITY != 0) ? PAR : STOP;
               end else begin
                  w_txBitNext = r_txBit + 1'b1;
               end
            end
         end
         PAR: begin
            w_txLine = r_txParity;
            if (w_txBitEnd) begin
               w_txStateNext = STOP;
               w_txCntNext   = '0;
               w_txBitNext   = '0;
            end
         end
         STOP: begin
            w_txLine = 1'b1;
            if (w_txBitEnd) begin
               w_txCntNext = '0;
               if (r_txBit == LASTSTOP) begin
                  w_txStateNext = IDLE;
                  w_txBitNext   = '0;
               end else begin
                  w_txBitNext = r_txBit + 1'b1;
               end
            end
         end
         default: w_txStateNext = IDLE;
      endcase
      if (rst) w_txLine = 1'b1;
   end

   // Transmit state register; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_txState  <= IDLE;
         r_txCnt    <= '0;
         r_txBit    <= '0;
         r_txShift  <= '0;
         r_txParity <= 1'b0;
      end else begin
         r_txState  <= w_txStateNext;
         r_txCnt    <= w_txCntNext;
         r_txBit    <= w_txBitNext;
         r_txShift  <= w_txShiftNext;
         r_txParity <= w_txParityNext;
      end
   end

   // Two-flop synchronizer plus previous-sample register for falling-edge start detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= w_rxLine;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Receive sequencing: three samples around bit centre, decision on the last one.
   always_comb begin
      w_rxStateNext  = r_rxState;
      w_rxCntNext    = r_rxCnt + 1'b1;
      w_rxBitNext    = r_rxBit;
      w_rxShiftNext  = r_rxShift;
      w_rxParBitNext = r_rxParBit;
      w_samp0Next    = (r_rxCnt == SAMP0) ? r_sync2 : r_samp0;
      w_samp1Next    = (r_rxCnt == SAMP1) ? r_sync2 : r_samp1;
      w_rxOutNext    = r_rxOut;
      w_rxValidNext  = 1'b0;
      case (r_rxState)
         IDLE: begin
            w_rxCntNext = '0;
            if (r_prev && !r_sync2) w_rxStateNext = START;
         end
         START: begin
            if (w_rxCenter && w_rxMaj) begin
               w_rxStateNext = IDLE;
            end else if (w_rxBitEnd) begin
               w_rxStateNext = DATA;
               w_rxCntNext   = '0;
               w_rxBitNext   = '0;
            end
         end
         DATA: begin
            if (w_rxCenter) w_rxShiftNext = {w_rxMaj, r_rxShift[DATA_BITS-1:1]};
            if (w_rxBitEnd) begin
               w_rxCntNext = '0;
               if (r_rxBit == LASTDATA) begin
                  w_rxBitNext   = '0;
                  w_rxStateNext = (PARITY != 0) ? PAR : STOP;
               end else begin
                  w_rxBitNext = r_rxBit + 1'b1;
               end
            end
         end
         PAR: begin
            if (w_rxCenter) w_rxParBitNext = w_rxMaj;
            if (w_rxBitEnd) begin
               w_rxStateNext = STOP;
               w_rxCntNext   = '0;
            end
         end
         STOP: begin
            if (w_rxCenter) begin
               w_rxOutNext   = {~w_rxMaj, w_parErr, r_rxShift};
               w_rxValidNext = 1'b1;
               w_rxStateNext = IDLE;
            end
         end
         default: w_rxStateNext = IDLE;
      endcase
   end

   // Receive state register and the registered host-side word/strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rxState  <= IDLE;
         r_rxCnt    <= '0;
         r_rxBit    <= '0;
         r_rxShift  <= '0;
         r_rxParBit <= 1'b0;
         r_samp0    <= 1'b1;
         r_samp1    <= 1'b1;
         r_rxOut    <= '0;
         r_rxValid  <= 1'b0;
      end else begin
         r_rxState  <= w_rxStateNext;
         r_rxCnt    <= w_rxCntNext;
         r_rxBit    <= w_rxBitNext;
         r_rxShift  <= w_rxShiftNext;
         r_rxParBit <= w_rxParBitNext;
         r_samp0    <= w_samp0Next;
         r_samp1    <= w_samp1Next;
         r_rxOut    <= w_rxOutNext;
         r_rxValid  <= w_rxValidNext;
      end
   end
endmodule

// File: tb/tb_uart_core_p.sv
// Directed bench for uart_core_p: three instances cover odd-parity loopback
// and reset abort, even-parity external receive, and 7N2 back-to-back transmit.
`timescale 1ns/1ps
module tb_uart_core_p;
   localparam int CPB = 48;

   logic clk = 1'b0;
   logic rst1, rst2, rst3;
   logic lb1;
   logic lb2 = 1'b0;
   logic lb3 = 1'b0;
   logic serIn2;
   logic serOut1, serOut2, serOut3;

   int edgeCount = 0;
   int checkCount = 0;
   int passCount = 0;
   int strobes[3] = '{0, 0, 0};
   logic [9:0] lastData[3];
   int lastAt[3];
   logic prevValid[3] = '{1'b0, 1'b0, 1'b0};
   int multiStrobe = 0;
   int lowOut1 = 0;
   int j, k, a, a2, base;
   logic [9:0] frame1, frame2;

   uart_core_p_if #(.DATA_BITS(8)) bus1 ();
   uart_core_p_if #(.DATA_BITS(8)) bus2 ();
   uart_core_p_if #(.DATA_BITS(7)) bus3 ();

   uart_core_p #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst1), .LoopBack(lb1), .SerDataIn(serOut1),
      .SerDataOut(serOut1), .host(bus1)
   );

   uart_core_p #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
      .clk(clk), .rst(rst2), .LoopBack(lb2), .SerDataIn(serIn2),
      .SerDataOut(serOut2), .host(bus2)
   );

   uart_core_p #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut3 (
      .clk(clk), .rst(rst3), .LoopBack(lb3), .SerDataIn(serOut3),
      .SerDataOut(serOut3), .host(bus3)
   );

   // 100 MHz bench clock; only the clk-count relationships matter.
   always #5 clk = ~clk;

   // Count rising edges so event times can be compared in clk units.
   always @(posedge clk) edgeCount++;

   // Record every receive strobe and flag any strobe wider than one clk.
   always @(negedge clk) begin
      if (bus1.PalDataOutValid) begin
         strobes[0]++;
         lastData[0] = bus1.PalDataOut;
         lastAt[0] = edgeCount;
      end
      if (bus2.PalDataOutValid) begin
         strobes[1]++;
         lastData[1] = bus2.PalDataOut;
         lastAt[1] = edgeCount;
      end
      if (bus3.PalDataOutValid) begin
         strobes[2]++;
         lastData[2] = 10'(bus3.PalDataOut);
         lastAt[2] = edgeCount;
      end
      if (bus1.PalDataOutValid && prevValid[0]) multiStrobe++;
      if (bus2.PalDataOutValid && prevValid[1]) multiStrobe++;
      if (bus3.PalDataOutValid && prevValid[2]) multiStrobe++;
      prevValid[0] = bus1.PalDataOutValid;
      prevValid[1] = bus2.PalDataOutValid;
      prevValid[2] = bus3.PalDataOutValid;
      if (lb1 && !serOut1) lowOut1++;
   end

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // Drives serIn2 with a frame LSB first, CPB clk per bit; optionally inverts one clk.
   task automatic applyStimulus(input logic [15:0] bits, input int nBits, input int glitchBit, input int glitchOff);
      for (int i = 0; i < nBits; i++) begin
         for (int c = 0; c < CPB; c++) begin
            serIn2 = (i == glitchBit && c == glitchOff) ? ~bits[i] : bits[i];
            @(negedge clk);
         end
      end
   endtask

   task automatic waitUntil(input int target);
      while (edgeCount < target) @(negedge clk);
   endtask

   initial begin
      rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
      lb1 = 1'b1; serIn2 = 1'b1;
      bus1.PalDataIn = '0; bus1.PalDataInEn = 1'b0;
      bus2.PalDataIn = '0; bus2.PalDataInEn = 1'b0;
      bus3.PalDataIn = '0; bus3.PalDataInEn = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rstPermit", 32'(bus1.PalDataInPermit), 32'd0);
      checkOutput("rstSerOut", 32'(serOut3), 32'd1);
      checkOutput("rstValid", 32'(bus2.PalDataOutValid), 32'd0);
      checkOutput("rstData", 32'(bus2.PalDataOut), 32'd0);
      rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
      #1;
      checkOutput("relPermit", 32'(bus1.PalDataInPermit), 32'd1);
      @(negedge clk);

      // Loopback, odd parity, 0xA5
      base = strobes[0];
      j = edgeCount;
      bus1.PalDataIn = 8'hA5;
      bus1.PalDataInEn = 1'b1;
      @(negedge clk);
      bus1.PalDataInEn = 1'b0;
      checkOutput("lbPermitDrop", 32'(bus1.PalDataInPermit), 32'd0);
      repeat (560) @(negedge clk);
      checkOutput("lbStrobes", 32'(strobes[0] - base), 32'd1);
      checkOutput("lbData", 32'(lastData[0]), 32'h0A5);
      checkOutput("lbTiming", 32'(lastAt[0] - j), 32'd509);
      checkOutput("lbSerOutHigh", 32'(lowOut1), 32'd0);
      checkOutput("lbPermitBack", 32'(bus1.PalDataInPermit), 32'd1);

      // Even parity, 0x3C with inverted parity bit
      base = strobes[1];
      k = edgeCount;
      applyStimulus({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, -1, 0);
      repeat (20) @(negedge clk);
      checkOutput("parStrobes", 32'(strobes[1] - base), 32'd1);
      checkOutput("parData", 32'(lastData[1]), 32'h13C);
      checkOutput("parTiming", 32'(lastAt[1] - k), 32'd508);

      // 0x55 with stop bit 0 and line held low afterwards
      base = strobes[1];
      applyStimulus({5'b0, 1'b0, 1'b0, 8'h55, 1'b0}, 11, -1, 0);
      repeat (5) @(negedge clk);
      checkOutput("frmStrobes", 32'(strobes[1] - base), 32'd1);
      checkOutput("frmData", 32'(lastData[1]), 32'h255);
      repeat (600) @(negedge clk);
      checkOutput("frmStuckLow", 32'(strobes[1] - base), 32'd1);
      serIn2 = 1'b1;
      repeat (100) @(negedge clk);
      checkOutput("frmLineHigh", 32'(strobes[1] - base), 32'd1);
      applyStimulus({5'b0, 1'b1, 1'b0, 8'h96, 1'b0}, 11, -1, 0);
      repeat (20) @(negedge clk);
      checkOutput("frmRecover", 32'(strobes[1] - base), 32'd2);
      checkOutput("frmRecoverData", 32'(lastData[1]), 32'h096);

      // 10-clk low glitch, then a frame with a 1-clk glitch at a data-bit centre
      base = strobes[1];
      serIn2 = 1'b0;
      repeat (10) @(negedge clk);
      serIn2 = 1'b1;
      repeat (200) @(negedge clk);
      checkOutput("glitchNoStrobe", 32'(strobes[1] - base), 32'd0);
      applyStimulus({5'b0, 1'b1, 1'b0, 8'hC3, 1'b0}, 11, 3, 24);
      repeat (20) @(negedge clk);
      checkOutput("glitchStrobes", 32'(strobes[1] - base), 32'd1);
      checkOutput("glitchData", 32'(lastData[1]), 32'h0C3);

      // 7N2 back-to-back transmit with PalDataInEn held high
      base = strobes[2];
      frame1 = {2'b11, 7'h01, 1'b0};
      frame2 = {2'b11, 7'h7F, 1'b0};
      bus3.PalDataIn = 7'h01;
      bus3.PalDataInEn = 1'b1;
      @(negedge clk);
      a = edgeCount;
      bus3.PalDataIn = 7'h7F;
      checkOutput("txPermitDrop", 32'(bus3.PalDataInPermit), 32'd0);
      for (int b = 0; b < 10; b++) begin
         waitUntil(a + b * CPB + 24);
         checkOutput($sformatf("tx1Bit%0d", b), 32'(serOut3), 32'(frame1[b]));
      end
      waitUntil(a + 479);
      checkOutput("txPermitLate", 32'(bus3.PalDataInPermit), 32'd0);
      checkOutput("txLastStop", 32'(serOut3), 32'd1);
      waitUntil(a + 480);
      checkOutput("txPermitRise", 32'(bus3.PalDataInPermit), 32'd1);
      checkOutput("txGap", 32'(serOut3), 32'd1);
      waitUntil(a + 481);
      a2 = a + 481;
      checkOutput("txStart2", 32'(serOut3), 32'd0);
      checkOutput("txPermit2Drop", 32'(bus3.PalDataInPermit), 32'd0);
      bus3.PalDataInEn = 1'b0;
      for (int b = 1; b < 10; b++) begin
         waitUntil(a2 + b * CPB + 24);
         checkOutput($sformatf("tx2Bit%0d", b), 32'(serOut3), 32'(frame2[b]));
      end
      waitUntil(a2 + 480);
      checkOutput("txPermit2Rise", 32'(bus3.PalDataInPermit), 32'd1);
      repeat (20) @(negedge clk);
      checkOutput("txRxStrobes", 32'(strobes[2] - base), 32'd2);
      checkOutput("txRxData", 32'(lastData[2]), 32'h07F);

      // Reset pulsed mid-TX/mid-RX on the external-loop path
      lb1 = 1'b0;
      @(negedge clk);
      base = strobes[0];
      bus1.PalDataIn = 8'h3C;
      bus1.PalDataInEn = 1'b1;
      @(negedge clk);
      bus1.PalDataInEn = 1'b0;
      a = edgeCount;
      waitUntil(a + 60);
      checkOutput("midTxLow", 32'(serOut1), 32'd0);
      rst1 = 1'b1;
      #1;
      checkOutput("rstMidSerOut", 32'(serOut1), 32'd1);
      checkOutput("rstMidPermit", 32'(bus1.PalDataInPermit), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("rstHoldSerOut", 32'(serOut1), 32'd1);
      checkOutput("rstHoldPermit", 32'(bus1.PalDataInPermit), 32'd0);
      checkOutput("rstClearsOut", 32'(bus1.PalDataOut), 32'd0);
      rst1 = 1'b0;
      #1;
      checkOutput("rstRelPermit", 32'(bus1.PalDataInPermit), 32'd1);
      repeat (600) @(negedge clk);
      checkOutput("abortNoStrobe", 32'(strobes[0] - base), 32'd0);
      bus1.PalDataIn = 8'h5A;
      bus1.PalDataInEn = 1'b1;
      @(negedge clk);
      bus1.PalDataInEn = 1'b0;
      repeat (560) @(negedge clk);
      checkOutput("postRstStrobes", 32'(strobes[0] - base), 32'd1);
      checkOutput("postRstData", 32'(lastData[0]), 32'h05A);

      checkOutput("singleClkStrobe", 32'(multiStrobe), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/uart_core_p.md
# uart_core_p

Parametrised full-duplex UART core: the next generation of the team's 256 kbps UART, generalised in data width, parity mode, stop-bit count and bit timing, with majority-vote receive sampling, framing/parity error reporting and an internal loopback mode. It sits between the serial pins and the parallel host logic, and keeps the established serial/parallel port set. Default timing is 12.288 MHz clk, 16× oversample × 3 prescale, giving 48 clk per bit and 256000 bps.

## Interface
- DATA_BITS, 8, payload bits per frame (5..9).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits transmitted (1 or 2); the receiver checks the first stop bit only.
- OVERSAMPLE, 16, samples per bit.
- PRESCALE, 3, clk per sample; CPB = OVERSAMPLE*PRESCALE clk per bit, CPB ≥ 4.
- clk  in  1  core clock; everything is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- LoopBack  in  1  1 = receiver reads internal TX line; SerDataOut held 1.
- SerDataIn  in  1  serial receive pin, asynchronous.
- PalDataOut  out  DATA_BITS+2  {frame_err, parity_err, data[DATA_BITS-1:0]}; data LSB is the first bit received.
- PalDataOutValid  out  1  one-clk strobe qualifying PalDataOut.
- PalDataIn  in  DATA_BITS  transmit word.
- PalDataInEn  in  1  transmit request.
- PalDataInPermit  out  1  transmitter ready.
- SerDataOut  out  1  serial transmit pin; idles at 1.

## Operation
- Reset values:
  - SerDataOut = 1, PalDataInPermit = 0 during rst and 1 from the first clk after release.
  - PalDataOutValid = 0, PalDataOut = 0.
  - Both FSMs enter IDLE. The 2-FF input synchronizer presets to 1.
- Reset asserted mid-frame aborts both directions immediately. No strobe is emitted for the partial frame.
- RX path: SerDataIn (or the internal TX line when LoopBack = 1) passes through the 2-FF synchronizer.
- RX FSM states are IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE.
- IDLE: a start is detected only on a falling edge, i.e. previous synchronized sample 1 and current sample 0. The detection cycle is D, and the bit counter is cleared at D.
- Bit sampling: each bit spans CPB clk. Samples are taken at bit offsets CPB/2-1, CPB/2 and CPB/2+1, and the bit value is the 2-of-3 majority.
- START: if the majority is 1, the event is a false start; return to IDLE and emit no strobe.
- DATA: bits shift in LSB first.
- PARITY: parity_err = 1 if data^parity violates the selected mode. Odd parity means the total count of ones is odd. parity_err is always 0 when PARITY = 0.
- STOP: frame_err = 1 if the stop majority is 0. The FSM then loads PalDataOut, pulses PalDataOutValid and returns to IDLE.
- After a framing error with the line stuck low, no new frame starts until a 1→0 edge occurs.
- TX path: the FSM states are IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE.
- TX accept: on a clk with PalDataInEn & PalDataInPermit, the core latches PalDataIn and drops Permit on the next clk. PalDataInEn is ignored while Permit = 0.
- TX frame: each bit lasts exactly CPB clk. The order is start 0, data LSB first, optional parity, then STOP_BITS stop bits at 1.
- PalDataInPermit is the IDLE-state decode.
- LoopBack switches routing only; the RX/TX FSMs behave identically in both modes. Changing LoopBack mid-frame is undefined.

## Timing
- N = 1 + DATA_BITS + (PARITY != 0); T_TX = N + STOP_BITS.
- RX latency:
  - Pin fall to D is 2–3 clk (synchronizer plus edge detect).
  - PalDataOutValid is high in exactly one clk, at D + CPB*N + CPB/2 + 2.
  - PalDataOut holds its value until the next strobe.
- TX:
  - Accept at clk A.
  - SerDataOut start bit spans clk A+1 .. A+CPB.
  - Last stop bit ends at A + CPB*T_TX.
  - Permit = 1 at A + CPB*T_TX + 1.
- Back-to-back TX with PalDataInEn held high inserts exactly 1 extra idle clk between frames.
- RX can accept a new start edge from the clk after the strobe, so 1-stop-bit back-to-back input frames are received without loss.
- RX and TX are fully independent; simultaneous accept and strobe in the same clk are both honoured.

## Test plan
- Defaults with PARITY = 1 and LoopBack = 1: send 0xA5 → one strobe with PalDataOut = 10'h0A5, timed at D + 48*10 + 26 after the start edge; SerDataOut stays 1 throughout.
- PARITY = 2: external frame 0x3C with the parity bit inverted → PalDataOut = 10'h13C (parity_err = 1).
- External frame 0x55 with the stop bit driven 0 and the line held low → PalDataOut = 10'h255 (frame_err = 1), then no further strobe until the line goes high and falls again.
- 10-clk low glitch on SerDataIn → no strobe and the FSM returns to IDLE. A single-clk 1 glitch at a data-bit center sample → majority still yields the correct byte.
- DATA_BITS = 7, STOP_BITS = 2, PalDataInEn held high with words 0x01, 0x7F:
  - Permit drops at A+1 and rises at A + 48*10 + 1.
  - Frames are separated by exactly 1 extra clk.
  - The bit pattern on SerDataOut is correct.
- rst pulsed mid-TX and mid-RX → SerDataOut = 1 and Permit = 0 during rst; Permit = 1 the clk after release; no strobe for the aborted frame; the next full frame is received correctly.
